// File: rtl/sd_multi_wr_ctrl.sv
// Multi-sector write sequencer for the single-sector SD SPI write engine.
// Buffers a full sector in the upstream FIFO before each kick and feeds engine word requests from it.
module sd_multi_wr_ctrl #(
   parameter int unsigned SEC_WORDS    = 256,
   parameter int unsigned START_HOLD   = 2,
   parameter int unsigned BUSY_TIMEOUT = 1024,
   parameter int unsigned CNT_W        = 10
) (
   input  logic             clk_ref,
   input  logic             rst_n,
   input  logic             sd_init_done,
   input  logic             start,
   input  logic [31:0]      start_sec,
   input  logic [15:0]      sec_num,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      sec_written,
   input  logic [CNT_W-1:0] fifo_rd_cnt,
   input  logic [15:0]      fifo_dout,
   output logic             fifo_rd_en,
   output logic             wr_start_en,
   output logic [31:0]      wr_sec_addr,
   output logic [15:0]      wr_data,
   input  logic             wr_busy,
   input  logic             wr_req
);

   localparam int unsigned TMO_W  = $clog2(BUSY_TIMEOUT + 1);
   localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
   localparam int unsigned WC_W   = $clog2(SEC_WORDS + 1) + 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      KICK,
      WAIT_BUSY,
      XFER,
      NEXT,
      FINISH
   } state_t;

   state_t            state;
   logic              start_q;
   logic              rd_en_q;
   logic [31:0]       addr;
   logic [15:0]       remaining;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [WC_W-1:0]   pops_now;

   always_comb begin
      fifo_rd_en = (state == XFER) && wr_req;
   end

   // A request arriving on the busy-fall cycle must still count toward the sector total.
   always_comb begin
      pops_now = word_cnt + WC_W'(fifo_rd_en);
   end

   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         start_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         addr        <= '0;
         remaining   <= '0;
         hold_cnt    <= '0;
         tmo_cnt     <= '0;
         word_cnt    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         sec_written <= '0;
         wr_start_en <= 1'b0;
         wr_sec_addr <= '0;
         wr_data     <= '0;
      end else begin
         start_q <= start;
         done    <= 1'b0;
         rd_en_q <= fifo_rd_en;
         if (rd_en_q) begin
            wr_data <= fifo_dout;
         end

         case (state)
            IDLE: begin
               if (start && !start_q && sd_init_done) begin
                  addr        <= start_sec;
                  remaining   <= sec_num;
                  error       <= 1'b0;
                  sec_written <= '0;
                  busy        <= 1'b1;
                  state       <= (sec_num == '0) ? FINISH : WAIT_DATA;
               end
            end

            WAIT_DATA: begin
               if (32'(fifo_rd_cnt) >= SEC_WORDS) begin
                  wr_sec_addr <= addr;
                  wr_start_en <= 1'b1;
                  hold_cnt    <= '0;
                  tmo_cnt     <= '0;
                  word_cnt    <= '0;
                  state       <= KICK;
               end
            end

            KICK: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (hold_cnt == HOLD_W'(START_HOLD - 1)) begin
                  wr_start_en <= 1'b0;
                  state       <= WAIT_BUSY;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            WAIT_BUSY: begin
               if (wr_busy) begin
                  state <= XFER;
               end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
                  error <= 1'b1;
                  state <= FINISH;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            XFER: begin
               if (fifo_rd_en && (word_cnt != '1)) begin
                  word_cnt <= word_cnt + 1'b1;
               end
               if (!wr_busy) begin
                  if (pops_now != WC_W'(SEC_WORDS)) begin
                     error <= 1'b1;
                     state <= FINISH;
                  end else begin
                     state <= NEXT;
                  end
               end
            end

            NEXT: begin
               addr        <= addr + 32'd1;
               sec_written <= sec_written + 16'd1;
               remaining   <= remaining - 16'd1;
               state       <= (remaining == 16'd1) ? FINISH : WAIT_DATA;
            end

            FINISH: begin
               if (!wr_busy) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
